// File: rtl/prog_loader_if.sv
// Host byte-stream handshake between the program source and the loader.
interface prog_loader_if;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;

  modport master (output host_valid, output host_data, input host_ready);
  modport slave  (input host_valid, input host_data, output host_ready);
endinterface

// File: rtl/prog_loader.sv
// Streams a length-prefixed, checksummed program from a host into instruction
// memory and releases the processor reset only after a verified load.
module prog_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  prog_loader_if.slave  host,
  output logic          wr_en,
  output logic [15:0]   wr_addr,
  output logic [8:0]    wr_data,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, INS_HI, INS_LO, CHECK, DONE, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        hi_q, hi_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [8:0]  wr_data_q, wr_data_d;

  logic        ready;
  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] cnt_inc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      hi_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    ready    = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == INS_HI) ||
               (state_q == INS_LO) || (state_q == CHECK);
    xfer     = ready && host.host_valid;
    len_full = {len_q[15:8], host.host_data};
    cnt_inc  = cnt_q + 16'd1;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          len_d   = '0;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d   = {host.host_data, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (32'(len_full) > MAX_WORDS) state_d = ERR;
          else if (len_full == 16'd0)    state_d = CHECK;
          else                           state_d = INS_HI;
        end
      end
      INS_HI: begin
        if (xfer) begin
          if (host.host_data[7:1] != 7'd0) begin
            state_d = ERR;
          end else begin
            hi_d    = host.host_data[0];
            csum_d  = csum_q + host.host_data;
            state_d = INS_LO;
          end
        end
      end
      INS_LO: begin
        if (xfer) begin
          // cnt_q doubles as the write address; compare its incremented value to N
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = {hi_q, host.host_data};
          csum_d    = csum_q + host.host_data;
          cnt_d     = cnt_inc;
          state_d   = (cnt_inc == len_q) ? CHECK : INS_HI;
        end
      end
      CHECK: begin
        if (xfer) state_d = (host.host_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  assign host.host_ready = ready;
  assign wr_en           = wr_en_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign done            = (state_q == DONE);
  assign error           = (state_q == ERR);
  assign cpu_reset       = (state_q != DONE);

endmodule
